// File: rtl/radio_pkg.sv
// Shared types and constants for the multi-radio 1-bit I/Q capture front end.
package radio_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE  = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_CONST = 2'd2
    } mode_e;

    // Fibonacci feedback taps 16,14,13,11 expressed as a state-bit mask
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // The all-zero state would lock the register, so it is replaced by 1
    function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int unsigned ch);
        logic [15:0] s;
        s = base ^ 16'(ch);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/radio_lfsr16.sv
// Per-channel 16-bit Fibonacci LFSR test-pattern source; iq = {Q, I} = state[1:0].
// Zero latency from state to output; advances only when step is high, no backpressure.
module radio_lfsr16
    import radio_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       clk16,
    input  logic       rst,
    input  logic       step,
    output logic [1:0] iq
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (step) begin
            state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign iq = state_q[1:0];

endmodule

// File: rtl/radio_capture.sv
// Syncs CHANNELS 1-bit I/Q radios, optionally substitutes test patterns, packs WIDTH samples per word.
// Pins reach the packer after 2 cycles; one-deep output register, a word completing while it is stalled is dropped and flags overflow.
module radio_capture
    import radio_pkg::*;
#(
    parameter int          CHANNELS  = 4,
    parameter int          WIDTH     = 8,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                            clk16,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic                            clear_ovf,
    input  logic [CHANNELS-1:0]             i_in,
    input  logic [CHANNELS-1:0]             q_in,
    output logic [2*CHANNELS*WIDTH-1:0]     m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            overflow
);

    localparam int DW    = 2 * CHANNELS * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    logic [CHANNELS-1:0] i_s1_q, i_s1_d, i_s2_q, i_s2_d;
    logic [CHANNELS-1:0] q_s1_q, q_s1_d, q_s2_q, q_s2_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_eff;
    logic [DW-1:0]       acc_q, acc_d;
    logic [DW-1:0]       tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                ovf_q, ovf_d;

    logic                     lfsr_step;
    logic [CHANNELS-1:0][1:0] lfsr_iq;
    logic [CHANNELS-1:0]      smp_i, smp_q;
    logic                     word_done;
    logic                     load;

    assign lfsr_step = enable && (mode == MODE_LFSR);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lfsr
        radio_lfsr16 #(
            .SEED (lfsr_seed(LFSR_SEED, c))
        ) u_lfsr (
            .clk16 (clk16),
            .rst   (rst),
            .step  (lfsr_step),
            .iq    (lfsr_iq[c])
        );
    end

    always_comb begin
        i_s1_d = i_in;
        q_s1_d = q_in;
        i_s2_d = i_s1_q;
        q_s2_d = q_s1_q;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode)
                MODE_LFSR: begin
                    smp_i[c] = lfsr_iq[c][0];
                    smp_q[c] = lfsr_iq[c][1];
                end
                MODE_CONST: begin
                    smp_i[c] = 1'b1;
                    smp_q[c] = 1'b0;
                end
                default: begin
                    smp_i[c] = i_s2_q[c];
                    smp_q[c] = q_s2_q[c];
                end
            endcase
        end
    end

    // A mode change restarts the word; positions are overwritten, so stale bits never escape
    always_comb begin
        mode_d    = mode;
        cnt_eff   = (mode != mode_q) ? '0 : cnt_q;
        cnt_d     = cnt_eff;
        acc_d     = acc_q;
        word_done = 1'b0;
        if (enable) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (cnt_eff == CNT_W'(k)) begin
                        acc_d[2*c*WIDTH + k]     = smp_i[c];
                        acc_d[(2*c+1)*WIDTH + k] = smp_q[c];
                    end
                end
            end
            if (cnt_eff == CNT_W'(WIDTH - 1)) begin
                word_done = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_eff + 1'b1;
            end
        end
    end

    always_comb begin
        load     = word_done && (!tvalid_q || m_tready);
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = acc_d;
        end else if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end
        // A drop in the same cycle as a clear leaves the flag set
        if (word_done && !load) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk16 or posedge rst) begin
        if (rst) begin
            i_s1_q   <= '0;
            i_s2_q   <= '0;
            q_s1_q   <= '0;
            q_s2_q   <= '0;
            mode_q   <= MODE_LIVE;
            cnt_q    <= '0;
            acc_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            i_s1_q   <= i_s1_d;
            i_s2_q   <= i_s2_d;
            q_s1_q   <= q_s1_d;
            q_s2_q   <= q_s2_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign overflow = ovf_q;

endmodule
